// File: rtl/sumador_serial.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with a carry register.
// The A shift register doubles as the result shift register; the sum fills it from the MSB.
module sumador_serial #(
    parameter int unsigned ANCHO = 8
) (
    input  logic             Reloj,
    input  logic             Reinicio,
    input  logic             Inicio,
    input  logic [ANCHO-1:0] OperandoA,
    input  logic [ANCHO-1:0] OperandoB,
    output logic             Ocupado,
    output logic             Listo,
    output logic [ANCHO-1:0] Suma,
    output logic             AcarreoSalida
);

    localparam int unsigned CW = $clog2(ANCHO + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

    typedef enum logic [1:0] {ESPERA, SUMANDO, LISTO} estado_t;

    estado_t          estado;
    logic [ANCHO-1:0] reg_a;
    logic [ANCHO-1:0] reg_b;
    logic             acarreo;
    logic [CW-1:0]    cuenta;
    logic             bit_suma;
    logic             acarreo_sig;
    logic [ANCHO-1:0] reg_a_sig;

    assign bit_suma    = reg_a[0] ^ reg_b[0] ^ acarreo;
    assign acarreo_sig = (reg_a[0] & reg_b[0]) | (reg_a[0] & acarreo) | (reg_b[0] & acarreo);
    // Operand bit leaves at the LSB while the sum bit enters at the MSB.
    assign reg_a_sig   = {bit_suma, reg_a[ANCHO-1:1]};

    always_ff @(posedge Reloj or posedge Reinicio) begin
        if (Reinicio) begin
            estado        <= ESPERA;
            reg_a         <= '0;
            reg_b         <= '0;
            acarreo       <= 1'b0;
            cuenta        <= '0;
            Suma          <= '0;
            AcarreoSalida <= 1'b0;
            Listo         <= 1'b0;
            Ocupado       <= 1'b0;
        end else begin
            case (estado)
                ESPERA: begin
                    if (Inicio) begin
                        reg_a   <= OperandoA;
                        reg_b   <= OperandoB;
                        acarreo <= 1'b0;
                        cuenta  <= '0;
                        Ocupado <= 1'b1;
                        estado  <= SUMANDO;
                    end
                end
                SUMANDO: begin
                    reg_a   <= reg_a_sig;
                    reg_b   <= reg_b >> 1;
                    acarreo <= acarreo_sig;
                    cuenta  <= cuenta + CW'(1);
                    if (cuenta == ULTIMO) begin
                        Suma          <= reg_a_sig;
                        AcarreoSalida <= acarreo_sig;
                        Listo         <= 1'b1;
                        estado        <= LISTO;
                    end
                end
                LISTO: begin
                    Listo   <= 1'b0;
                    Ocupado <= 1'b0;
                    estado  <= ESPERA;
                end
                default: begin
                    Listo   <= 1'b0;
                    Ocupado <= 1'b0;
                    estado  <= ESPERA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_serial.sv
// Directed bench for sumador_serial: ANCHO=8 instance for timing/reset/vectors,
// ANCHO=3 instance for the exhaustive operand sweep.
module tb_sumador_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       ina = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ocup, listo, carry;
    logic [7:0] suma;

    logic       ina3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       ocup3, listo3, carry3;
    logic [2:0] suma3;

    int nerr = 0;
    int nchk = 0;

    logic [7:0] prev_sum = '0;
    logic       prev_c   = 1'b0;

    always #5 clk = ~clk;

    sumador_serial #(.ANCHO(8)) u_dut8 (
        .Reloj(clk), .Reinicio(rst), .Inicio(ina), .OperandoA(a8), .OperandoB(b8),
        .Ocupado(ocup), .Listo(listo), .Suma(suma), .AcarreoSalida(carry)
    );

    sumador_serial #(.ANCHO(3)) u_dut3 (
        .Reloj(clk), .Reinicio(rst), .Inicio(ina3), .OperandoA(a3), .OperandoB(b3),
        .Ocupado(ocup3), .Listo(listo3), .Suma(suma3), .AcarreoSalida(carry3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One start pulse, then wait (bounded) for Listo and compare against the hand value.
    task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_s, input logic exp_c);
        int  lat;
        logic busy_all;
        @(negedge clk);
        ina = 1'b1;
        a8  = a;
        b8  = b;
        @(posedge clk);
        #1;
        ina = 1'b0;
        a8  = ~a;
        b8  = ~b;
        lat = 0;
        busy_all = ocup;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            busy_all = busy_all & ocup;
            if (i == 1) check({tag, "_hold"}, {23'd0, prev_c, prev_sum}, {23'd0, prev_c, prev_sum} & 32'h0 | {23'd0, prev_c, prev_sum} ^ {23'd0, carry, suma} ^ {23'd0, prev_c, prev_sum});
            if (listo) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_busy"}, busy_all, 1);
        check({tag, "_sum"}, suma, exp_s);
        check({tag, "_carry"}, carry, exp_c);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {listo, ocup}, 2'b00);
        prev_sum = exp_s;
        prev_c   = exp_c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ha[30];
        logic [7:0] hb[30];
        logic [8:0] tot;
        logic       seen;
        logic [3:0] prev3;
        logic       stable;
        logic       got;
        logic [5:0] pv;

        #1;
        check("rst_out8", {ocup, listo, carry, suma}, 11'd0);
        check("rst_out3", {ocup3, listo3, carry3, suma3}, 6'd0);
        @(negedge clk);
        rst = 1'b0;

        run_add("zero", 8'h00, 8'h00, 8'h00, 1'b0);
        run_add("ff01", 8'hFF, 8'h01, 8'h00, 1'b1);
        run_add("6437", 8'h64, 8'h37, 8'h9B, 1'b0);
        run_add("c864", 8'hC8, 8'h64, 8'h2C, 1'b1);

        // Inicio held high: starts only at edges 0, 10, 20.
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            ina   = 1'b1;
            a8    = 8'(e * 37 + 5);
            b8    = 8'(e * 11 + 200);
            ha[e] = a8;
            hb[e] = b8;
            @(posedge clk);
            #1;
            check($sformatf("cont_listo%0d", e), listo, ((e % 10) == 8));
            if ((e % 10) == 8) begin
                tot = {1'b0, ha[e-8]} + {1'b0, hb[e-8]};
                check($sformatf("cont_res%0d", e), {carry, suma}, tot);
                prev_sum = tot[7:0];
                prev_c   = tot[8];
            end
        end
        @(negedge clk);
        ina = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in the middle of SUMANDO.
        @(negedge clk);
        ina = 1'b1;
        a8  = 8'h12;
        b8  = 8'h34;
        @(posedge clk);
        #1;
        ina = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out", {ocup, listo, carry, suma}, 11'd0);
        ina = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ign_start", ocup, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ina = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | listo | ocup;
        end
        check("abort_nolisto", seen, 1'b0);
        prev_sum = 8'h00;
        prev_c   = 1'b0;
        run_add("0ff0", 8'h0F, 8'hF0, 8'hFF, 1'b0);

        // ANCHO=3 exhaustive, back to back.
        prev3 = 4'd0;
        for (int p = 0; p < 64; p++) begin
            pv = p[5:0];
            @(negedge clk);
            ina3 = 1'b1;
            a3   = pv[5:3];
            b3   = pv[2:0];
            @(posedge clk);
            #1;
            ina3   = 1'b0;
            stable = 1'b1;
            got    = 1'b0;
            for (int i = 1; i <= 10; i++) begin
                @(posedge clk);
                #1;
                if (listo3) begin
                    got = 1'b1;
                    break;
                end
                if ({carry3, suma3} !== prev3) stable = 1'b0;
            end
            check($sformatf("w3_listo_%0d", p), got, 1'b1);
            check($sformatf("w3_sum_%0d", p), {carry3, suma3}, {1'b0, pv[5:3]} + {1'b0, pv[2:0]});
            check($sformatf("w3_stable_%0d", p), stable, 1'b1);
            prev3 = {1'b0, pv[5:3]} + {1'b0, pv[2:0]};
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sumador_serial.md
SUMADOR_SERIAL -- requirements
Module: sumador_serial

Interface
REQ-001 The block SHALL have parameter ANCHO, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port Reloj, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port Reinicio, input, 1 bit, the reset: asynchronous and active-high.
REQ-004 The block SHALL have port Inicio, input, 1 bit, the start request, sampled on the rising edge.
REQ-005 The block SHALL have port OperandoA, input, ANCHO bits, the first addend, captured when a start is accepted.
REQ-006 The block SHALL have port OperandoB, input, ANCHO bits, the second addend, captured when a start is accepted.
REQ-007 The block SHALL have port Ocupado, output, 1 bit, high while an addition is in progress.
REQ-008 The block SHALL have port Listo, output, 1 bit, a one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port Suma, output, ANCHO bits, the registered sum of the last completed addition.
REQ-010 The block SHALL have port AcarreoSalida, output, 1 bit, the registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL implement a bit-serial adder: one full-adder evaluation per clock, LSB first, with a 1-bit carry register between evaluations.
REQ-012 The FSM SHALL have three states: ESPERA (idle), SUMANDO (busy), LISTO (done).
REQ-013 In ESPERA, an edge with Inicio=1 SHALL load OperandoA/OperandoB into internal shift registers, clear the carry register, clear the bit counter, and move to SUMANDO.
REQ-014 In ESPERA, an edge with Inicio=0 SHALL leave all state unchanged.
REQ-015 Each SUMANDO edge SHALL compute s = a0 XOR b0 XOR c and c' = majority(a0, b0, c), where a0/b0 are the shift-register LSBs; it SHALL shift s into the result-shift MSB, shift both operand registers right by one, and increment the counter.
REQ-016 The counter SHALL be ceil(log2(ANCHO+1)) bits wide; SUMANDO SHALL last exactly ANCHO edges.
REQ-017 On the ANCHO-th SUMANDO edge, Suma SHALL load the complete ANCHO-bit result, AcarreoSalida SHALL load c', and the state SHALL move to LISTO.
REQ-018 In LISTO, Listo SHALL be 1 for exactly one cycle; the next edge SHALL return the state to ESPERA unconditionally.
REQ-019 Latency: Inicio accepted at edge 0 SHALL give Listo=1 in the cycle following edge ANCHO (ANCHO+1 cycles total); the earliest next accepted start is edge ANCHO+2.
REQ-020 Ocupado SHALL be 1 exactly in SUMANDO and LISTO, and 0 in ESPERA.
REQ-021 Inicio SHALL be ignored in SUMANDO and LISTO; operand changes after capture SHALL have no effect on the running addition.
REQ-022 Suma and AcarreoSalida SHALL hold their last completed value through ESPERA and through the next SUMANDO, changing only at REQ-017.
REQ-023 The result SHALL equal (OperandoA + OperandoB) mod 2^ANCHO, and AcarreoSalida SHALL equal bit ANCHO of the (ANCHO+1)-bit true sum.

Reset
REQ-024 Reinicio=1 SHALL immediately, without a clock edge, force state ESPERA and clear the counter, carry, shift registers, Suma, AcarreoSalida, Listo and Ocupado to 0.
REQ-025 A reset during SUMANDO or LISTO SHALL abort the addition with no Listo pulse; after release, the first accepted Inicio SHALL start a fresh addition.
REQ-026 While Reinicio=1, Inicio SHALL be ignored; the first edge with Reinicio=0 and Inicio=1 SHALL be accepted.

Verification (ANCHO=8 unless stated)
REQ-027 A=0x00, B=0x00, Inicio pulse -> Listo at cycle 9, Suma=0x00, AcarreoSalida=0, Ocupado high for cycles 1..9.
REQ-028 A=0xFF, B=0x01 -> Suma=0x00, AcarreoSalida=1; A=0x64, B=0x37 -> Suma=0x9B, AcarreoSalida=0; A=0xC8, B=0x64 -> Suma=0x2C, AcarreoSalida=1.
REQ-029 Inicio held high continuously with operands changing each cycle -> starts accepted only at edges 0, 10, 20...; each result matches the operands captured at its accepting edge.
REQ-030 Reinicio asserted mid-SUMANDO (cycle 4) -> all outputs 0 immediately, no Listo pulse; a new start with A=0x0F, B=0xF0 then gives Suma=0xFF, AcarreoSalida=0.
REQ-031 ANCHO=3, all 64 operand pairs applied back to back -> every {AcarreoSalida, Suma} equals the 4-bit A+B, and Suma is stable between Listo pulses.
